// File: rtl/spi_arbiter.sv
// Shares one SPI monarch between an inertial sensor and an A2D converter.
// Define SPI_ARB_RR_EN for round-robin contention; default is inertial priority.
module spi_arbiter #(
  parameter int unsigned GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        mnrch_done,
  input  logic [15:0] mnrch_resp,
  input  logic        mnrch_SS_n,
  output logic        SS_n_inert,
  output logic        SS_n_a2d,
  output logic [15:0] rd_data,
  output logic        inert_done,
  output logic        a2d_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Last GAP count value; GAP lasts GAP_CYC clocks counting from zero.
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic        owner_a2d_q, owner_a2d_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        inert_done_q, inert_done_d;
  logic        a2d_done_q, a2d_done_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        grant_a2d;

`ifdef SPI_ARB_RR_EN
  // Resets to A2D so the first contention after reset favours inertial.
  logic        last_a2d_q, last_a2d_d;

  always_comb begin
    grant_a2d = a2d_req && (!inert_req || !last_a2d_q);
  end
`else
  always_comb begin
    grant_a2d = a2d_req && !inert_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_a2d_q  <= 1'b0;
      cmd_q        <= 16'h0000;
      rd_data_q    <= 16'h0000;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_a2d_q  <= owner_a2d_d;
      cmd_q        <= cmd_d;
      rd_data_q    <= rd_data_d;
      inert_done_q <= inert_done_d;
      a2d_done_q   <= a2d_done_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef SPI_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a2d_q <= 1'b1;
    end else begin
      last_a2d_q <= last_a2d_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    owner_a2d_d  = owner_a2d_q;
    cmd_d        = cmd_q;
    rd_data_d    = rd_data_q;
    inert_done_d = 1'b0;
    a2d_done_d   = 1'b0;
    gap_cnt_d    = gap_cnt_q;
`ifdef SPI_ARB_RR_EN
    last_a2d_d   = last_a2d_q;
`endif
    case (state_q)
      IDLE: begin
        if (inert_req || a2d_req) begin
          owner_a2d_d = grant_a2d;
          cmd_d       = grant_a2d ? a2d_cmd : inert_cmd;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        // Requests are no longer looked at here, so a dropped req still completes.
        if (mnrch_done) begin
          rd_data_d    = mnrch_resp;
          inert_done_d = !owner_a2d_q;
          a2d_done_d   = owner_a2d_q;
          gap_cnt_d    = 8'd0;
          state_d      = GAP;
`ifdef SPI_ARB_RR_EN
          last_a2d_d   = owner_a2d_q;
`endif
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign snd        = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign cmd        = cmd_q;
  assign rd_data    = rd_data_q;
  assign inert_done = inert_done_q;
  assign a2d_done   = a2d_done_q;
  // Only one owner exists at a time, so the two selects can never both be low.
  assign SS_n_inert = (busy && !owner_a2d_q) ? mnrch_SS_n : 1'b1;
  assign SS_n_a2d   = (busy &&  owner_a2d_q) ? mnrch_SS_n : 1'b1;

endmodule
